// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, byte-lane strobe codes and strobe legality check
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_HLO  = 4'b0011;
  localparam logic [3:0] BE_HHI  = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;
  function automatic logic be_legal(input logic [3:0] be);
    return be inside {BE_NONE, BE_B0, BE_B1, BE_B2, BE_B3, BE_HLO, BE_HHI, BE_WORD};
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with byte-lane write enables, write-first read, no reset
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  logic [31:0] merged;
  // Word as it will look after this access: written lanes take new data, others keep old
  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = we[i] ? wdata[8*i +: 8] : mem[addr][8*i +: 8];
  end
  // Lane writes and a read port that returns the freshly written word
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= merged;
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time load/store responder with configurable wait states
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_req,
  input  logic [31:0] data_addr,
  input  logic [3:0]  dmem_wr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q, cur_addr, cur_wdata, off, word;
  logic [3:0]  wr_q, cur_wr;
  logic [1:0]  lane_q;
  logic        err_q, bad, commit;
  // With zero wait states the commit happens on the accept edge, so live inputs are used there
  always_comb begin
    cur_addr  = state == IDLE ? data_addr : addr_q;
    cur_wr    = state == IDLE ? dmem_wr : wr_q;
    cur_wdata = state == IDLE ? dmem_wdata : wdata_q;
    off       = cur_addr - BASE_ADDR;
    bad       = cur_addr < BASE_ADDR || {1'b0, off} >= LIMIT || !be_legal(cur_wr);
    commit    = state == IDLE ? dmem_req && WAIT_STATES == 0 : state == WAIT && cnt == 4'd1;
  end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (commit && !bad),
    .we    (cur_wr),
    .addr  (off[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (word)
  );
  // Request FSM: capture, count down wait states, commit, then present the registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wr_q       <= '0;
      wdata_q    <= '0;
      lane_q     <= '0;
      err_q      <= 1'b0;
      dmem_ready <= 1'b0;
      dmem_rdata <= '0;
      dmem_err   <= 1'b0;
    end else begin
      dmem_ready <= state == RESP;
      if (commit) begin
        lane_q <= cur_addr[1:0];
        err_q  <= bad;
      end
      if (state == RESP) begin
        dmem_err   <= err_q;
        dmem_rdata <= err_q ? '0 : word >> {lane_q, 3'b000};
      end
      case (state)
        IDLE: if (dmem_req) begin
          addr_q  <= data_addr;
          wr_q    <= dmem_wr;
          wdata_q <= dmem_wdata;
          cnt     <= 4'(WAIT_STATES);
          state   <= WAIT_STATES == 0 ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table vectors, multi-cycle corner sequences and randomized traffic vs a word-array model
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int WS = 1;
  localparam logic [31:0] BASE = 32'h0;
  logic        clk = 1'b0, rst = 1'b1, dmem_req = 1'b0;
  logic [31:0] data_addr = '0, dmem_wdata = '0;
  logic [3:0]  dmem_wr = '0;
  logic        dmem_ready, dmem_err;
  logic [31:0] dmem_rdata;
  int vectors = 0, miscompares = 0;
  logic [31:0] ref_mem [int];
  typedef struct {
    logic [31:0] a;
    logic [3:0]  w;
    logic [31:0] d;
    logic        chk_rd;
    logic [31:0] rd;
    logic        e;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_req   (dmem_req),
    .data_addr  (data_addr),
    .dmem_wr    (dmem_wr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .dmem_err   (dmem_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                                output logic [31:0] rd, output logic e);
    logic [31:0] word;
    int idx;
    e = !(w inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF}) || a < BASE || (a - BASE) >= 4 * DEPTH;
    rd = '0;
    if (!e) begin
      idx = int'((a - BASE) / 4);
      word = ref_mem.exists(idx) ? ref_mem[idx] : '0;
      for (int i = 0; i < 4; i++) if (w[i]) word[8*i +: 8] = d[8*i +: 8];
      ref_mem[idx] = word;
      rd = word >> (8 * (a % 4));
    end
  endfunction

  task automatic xact(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int lat);
    dmem_req = 1'b1;
    data_addr = a;
    dmem_wr = w;
    dmem_wdata = d;
    lat = 0;
    @(posedge clk); #1;
    data_addr = $urandom;
    dmem_wr = 4'($urandom);
    dmem_wdata = $urandom;
    while (!dmem_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = dmem_rdata;
    e = dmem_err;
    dmem_req = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, exp_rd, a, d;
    logic [3:0] w;
    logic e, exp_e;
    int lat, pulses, last, cyc;
    tbl[0]  = '{32'h10,  4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{32'h10,  4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{32'h12,  4'h4, 32'h00AA0000, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{32'h12,  4'h0, 32'h0,        1'b1, 32'h0000DEAA, 1'b0};
    tbl[4]  = '{32'h12,  4'hC, 32'h12340000, 1'b0, 32'h0,        1'b0};
    tbl[5]  = '{32'h10,  4'h0, 32'h0,        1'b1, 32'h1234BEEF, 1'b0};
    tbl[6]  = '{32'h10,  4'h5, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
    tbl[7]  = '{32'h1000, 4'h0, 32'h0,       1'b1, 32'h0,        1'b1};
    tbl[8]  = '{32'h10,  4'h0, 32'h0,        1'b1, 32'h1234BEEF, 1'b0};
    tbl[9]  = '{32'h13,  4'h0, 32'h0,        1'b1, 32'h00000012, 1'b0};
    tbl[10] = '{32'h11,  4'h2, 32'h00005600, 1'b0, 32'h0,        1'b0};
    tbl[11] = '{32'h11,  4'h0, 32'h0,        1'b1, 32'h00123456, 1'b0};
    tbl[12] = '{32'hFFFFFFFC, 4'hF, 32'h0,   1'b1, 32'h0,        1'b1};
    tbl[13] = '{32'h14,  4'h6, 32'h11111111, 1'b1, 32'h0,        1'b1};
    tbl[14] = '{32'hFFC, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
    tbl[15] = '{32'hFFE, 4'h0, 32'h0,        1'b1, 32'h0000CAFE, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(dmem_ready), 32'd0);
    check("reset rdata", dmem_rdata, 32'h0);
    check("reset err", 32'(dmem_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      xact(tbl[i].a, tbl[i].w, tbl[i].d, rd, e, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(WS + 1));
      check($sformatf("vec%0d err", i), 32'(e), 32'(tbl[i].e));
      if (tbl[i].chk_rd) check($sformatf("vec%0d rdata", i), rd, tbl[i].rd);
    end

    dmem_req = 1'b1;
    data_addr = 32'h10;
    dmem_wr = 4'h0;
    pulses = 0;
    last = 0;
    cyc = 0;
    while (pulses < 3 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (dmem_ready) begin
        check("b2b rdata", dmem_rdata, 32'h123456EF);
        if (pulses > 0) check("b2b spacing", 32'(cyc - last), 32'(WS + 2));
        last = cyc;
        pulses++;
      end
    end
    dmem_req = 1'b0;
    check("b2b pulses", 32'(pulses), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    check("b2b quiet", 32'(dmem_ready), 32'd0);

    xact(32'h20, 4'hF, 32'h0BADCAFE, rd, e, lat);
    check("rst prep err", 32'(e), 32'd0);
    dmem_req = 1'b1;
    data_addr = 32'h20;
    dmem_wr = 4'hF;
    dmem_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("rst pre ready", 32'(dmem_ready), 32'd0);
    rst = 1'b1;
    #1;
    dmem_req = 1'b0;
    check("rst async rdata", dmem_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (dmem_ready) pulses++;
    end
    check("rst no pulse", 32'(pulses), 32'd0);
    xact(32'h20, 4'h0, 32'h0, rd, e, lat);
    check("rst old data", rd, 32'h0BADCAFE);
    check("rst old err", 32'(e), 32'd0);

    for (int i = 0; i < 16; i++) begin
      a = 32'h100 + 32'(4 * i);
      d = $urandom;
      model(a, 4'hF, d, exp_rd, exp_e);
      xact(a, 4'hF, d, rd, e, lat);
      check("init err", 32'(e), 32'(exp_e));
    end
    for (int n = 0; n < 150; n++) begin
      a = ($urandom % 8 == 0) ? 32'h1000 + ($urandom % 64) : 32'h100 + ($urandom % 64);
      w = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
      d = $urandom;
      model(a, w, d, exp_rd, exp_e);
      xact(a, w, d, rd, e, lat);
      check("rand latency", 32'(lat), 32'(WS + 1));
      check("rand err", 32'(e), 32'(exp_e));
      if (w == 4'h0 || exp_e) check("rand rdata", rd, exp_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
